// File: rtl/key_req_capture.sv
// Four-channel debounce, rising-edge detect and sticky pending capture feeding the 4-to-2 priority encoder.
// Optional `KEY_REQ_SYNC2_EN inserts a 2-flop synchronizer per key line (adds 2 cycles of latency).

module key_req_lane #(
  parameter int DB_CYCLES = 4,
  localparam int CW = $clog2(DB_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  input  logic clr,
  output logic lvl,
  output logic rise,
  output logic pend,
  output logic pend_nxt
);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          s;
  logic          flip;
  logic [CW-1:0] cnt;

`ifdef KEY_REQ_SYNC2_EN
  logic [1:0] sync;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[0], key};
  end
  assign s = sync[1];
`else
  assign s = key;
`endif

  // The level flips on the DB_CYCLES-th consecutive edge that disagrees with it.
  assign flip     = (s != lvl) && (cnt == LAST);
  assign pend_nxt = (flip && s) ? 1'b1 : (clr ? 1'b0 : pend);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      lvl  <= 1'b0;
      rise <= 1'b0;
      pend <= 1'b0;
    end else begin
      rise <= flip & s;
      pend <= pend_nxt;
      if (s == lvl) begin
        cnt <= '0;
      end else if (flip) begin
        lvl <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module key_req_capture #(
  parameter int DB_CYCLES = 4,
  localparam int CW = $clog2(DB_CYCLES)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_in,
  input  logic [3:0] clr,
  output logic [3:0] key_lvl,
  output logic [3:0] key_rise,
  output logic [3:0] pend,
  output logic       pend_any
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0] pend_nxt;

  key_req_lane #(.DB_CYCLES(DB_CYCLES)) u_lane [NUM_LANES-1:0] (
    .clk      (clk),
    .rst      (rst),
    .key      (key_in),
    .clr      (clr),
    .lvl      (key_lvl),
    .rise     (key_rise),
    .pend     (pend),
    .pend_nxt (pend_nxt)
  );

  // Registered from next-state pend so it tracks |pend with no extra cycle of lag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_any <= 1'b0;
    else     pend_any <= |pend_nxt;
  end
endmodule

// File: tb/tb_key_req_capture.sv
// Bench for key_req_capture: spec vector table, hand-written reset sequence, randomized run vs reference model.
module tb_key_req_capture;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_in = '0;
  logic [3:0] clr = '0;
  logic [3:0] key_lvl, key_rise, pend;
  logic       pend_any;

  int errors = 0;
  int checks = 0;

  key_req_capture #(.DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .clr(clr),
    .key_lvl(key_lvl), .key_rise(key_rise), .pend(pend), .pend_any(pend_any)
  );

  always #5 clk = ~clk;

  // Reference model: a level flips once the last DB samples all hold the opposite value.
  logic [DB-1:0] hist [4];
  logic [3:0] m_lvl, m_rise, m_pend, m_s1, m_s2;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) hist[i] = '0;
    m_lvl = '0; m_rise = '0; m_pend = '0; m_s1 = '0; m_s2 = '0;
  endtask

  task automatic model_edge(input logic [3:0] k, input logic [3:0] c);
    logic [3:0] smp;
`ifdef KEY_REQ_SYNC2_EN
    smp = m_s2; m_s2 = m_s1; m_s1 = k;
`else
    smp = k;
`endif
    for (int i = 0; i < 4; i++) begin
      hist[i] = {hist[i][DB-2:0], smp[i]};
      m_rise[i] = 1'b0;
      if (hist[i] == (m_lvl[i] ? {DB{1'b0}} : {DB{1'b1}})) begin
        m_lvl[i]  = ~m_lvl[i];
        m_rise[i] = m_lvl[i];
      end
      if (m_rise[i])  m_pend[i] = 1'b1;
      else if (c[i])  m_pend[i] = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("lvl_model",  key_lvl, m_lvl);
    chk("rise_model", key_rise, m_rise);
    chk("pend_model", pend, m_pend);
    chk("any_model",  {3'b0, pend_any}, {3'b0, |m_pend});
  endtask

  // Drive inputs, clock one edge, sample 1ns after it.
  task automatic step(input logic [3:0] k, input logic [3:0] c);
    key_in = k; clr = c;
    @(posedge clk);
    model_edge(k, c);
    #1;
  endtask

  typedef struct {
    logic [3:0] k, c, lvl, rise, pnd;
  } vec_t;
  vec_t tbl [34];

  initial begin
    tbl = '{
      // clean press ch2, then clear it
      '{4'b0100,4'b0000,4'b0000,4'b0000,4'b0000}, '{4'b0100,4'b0000,4'b0000,4'b0000,4'b0000},
      '{4'b0100,4'b0000,4'b0000,4'b0000,4'b0000}, '{4'b0100,4'b0000,4'b0100,4'b0100,4'b0100},
      '{4'b0100,4'b0000,4'b0100,4'b0000,4'b0100}, '{4'b0100,4'b0100,4'b0100,4'b0000,4'b0000},
      // bounce on ch1: 1,1,1,0,1,1,1,1
      '{4'b0110,4'b0000,4'b0100,4'b0000,4'b0000}, '{4'b0110,4'b0000,4'b0100,4'b0000,4'b0000},
      '{4'b0110,4'b0000,4'b0100,4'b0000,4'b0000}, '{4'b0100,4'b0000,4'b0100,4'b0000,4'b0000},
      '{4'b0110,4'b0000,4'b0100,4'b0000,4'b0000}, '{4'b0110,4'b0000,4'b0100,4'b0000,4'b0000},
      '{4'b0110,4'b0000,4'b0100,4'b0000,4'b0000}, '{4'b0110,4'b0000,4'b0110,4'b0010,4'b0010},
      // release without clear keeps pend
      '{4'b0000,4'b0000,4'b0110,4'b0000,4'b0010}, '{4'b0000,4'b0000,4'b0110,4'b0000,4'b0010},
      '{4'b0000,4'b0000,4'b0110,4'b0000,4'b0010}, '{4'b0000,4'b0000,4'b0000,4'b0000,4'b0010},
      '{4'b0000,4'b0010,4'b0000,4'b0000,4'b0000},
      // simultaneous multi-key 1011
      '{4'b1011,4'b0000,4'b0000,4'b0000,4'b0000}, '{4'b1011,4'b0000,4'b0000,4'b0000,4'b0000},
      '{4'b1011,4'b0000,4'b0000,4'b0000,4'b0000}, '{4'b1011,4'b0000,4'b1011,4'b1011,4'b1011},
      '{4'b1011,4'b0110,4'b1011,4'b0000,4'b1001},
      // release ch0/ch3, clear ch3, re-press with clr[0] on the set edge
      '{4'b0010,4'b0000,4'b1011,4'b0000,4'b1001}, '{4'b0010,4'b0000,4'b1011,4'b0000,4'b1001},
      '{4'b0010,4'b0000,4'b1011,4'b0000,4'b1001}, '{4'b0010,4'b0000,4'b0010,4'b0000,4'b1001},
      '{4'b0010,4'b1000,4'b0010,4'b0000,4'b0001},
      '{4'b1011,4'b0000,4'b0010,4'b0000,4'b0001}, '{4'b1011,4'b0000,4'b0010,4'b0000,4'b0001},
      '{4'b1011,4'b0000,4'b0010,4'b0000,4'b0001}, '{4'b1011,4'b0001,4'b1011,4'b1001,4'b1001},
      '{4'b1011,4'b1001,4'b1011,4'b0000,4'b0000}
    };

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_lvl", key_lvl, 4'b0000);
    chk("reset_rise", key_rise, 4'b0000);
    chk("reset_pend", pend, 4'b0000);
    chk("reset_any", {3'b0, pend_any}, 4'b0000);
    @(negedge clk) rst = 1'b0;

    for (int v = 0; v < 34; v++) begin
      step(tbl[v].k, tbl[v].c);
`ifndef KEY_REQ_SYNC2_EN
      chk($sformatf("tbl%0d_lvl", v),  key_lvl, tbl[v].lvl);
      chk($sformatf("tbl%0d_rise", v), key_rise, tbl[v].rise);
      chk($sformatf("tbl%0d_pend", v), pend, tbl[v].pnd);
      chk($sformatf("tbl%0d_any", v),  {3'b0, pend_any}, {3'b0, |tbl[v].pnd});
`endif
      chk_model();
    end

    // Randomized run: slow key toggling so debounce can complete, sparse clears.
    begin
      logic [3:0] k, c;
      k = '0;
      for (int n = 0; n < 600; n++) begin
        for (int i = 0; i < 4; i++) if ($urandom_range(5) == 0) k[i] = ~k[i];
        c = 4'($urandom) & 4'($urandom);
        step(k, c);
        chk_model();
      end
    end

    // Reset mid-operation with pend=0101 and all keys high.
    step(4'b0000, 4'b1111);
    repeat (DB + 3) begin step(4'b0000, 4'b0000); chk_model(); end
    repeat (DB + 3) begin step(4'b0101, 4'b0000); chk_model(); end
    chk("pre_rst_pend", pend, 4'b0101);
    step(4'b1111, 4'b0000);
    chk_model();
    #2 rst = 1'b1;
    #1;
    chk("async_lvl", key_lvl, 4'b0000);
    chk("async_rise", key_rise, 4'b0000);
    chk("async_pend", pend, 4'b0000);
    chk("async_any", {3'b0, pend_any}, 4'b0000);
    model_reset();
    @(negedge clk) rst = 1'b0;
    for (int e = 1; e <= DB + 3; e++) begin
      step(4'b1111, 4'b0000);
      chk_model();
`ifndef KEY_REQ_SYNC2_EN
      if (e == DB) begin
        chk("post_rst_lvl", key_lvl, 4'b1111);
        chk("post_rst_rise", key_rise, 4'b1111);
      end
      if (e == DB + 1) begin
        chk("post_rst_rise_off", key_rise, 4'b0000);
        chk("post_rst_pend", pend, 4'b1111);
        chk("post_rst_any", {3'b0, pend_any}, 4'b0001);
      end
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/key_req_capture.md
Name: key_req_capture

Overview:
- Upstream front end for the 4-to-2 priority encoder stage.
- Takes four raw, bouncy request/key lines and debounces each one independently.
- Detects debounced rising edges and holds them as sticky pending bits until software/control clears them.
- pend[3:0] drives the encoder's 4-bit request input; pend_any drives its enable.

Parameters:
- DB_CYCLES, 4, consecutive clock edges a changed sample must persist before the debounced level flips; legal range 2..65535.
- CW, $clog2(DB_CYCLES), width of each per-channel debounce counter; derived, never overridden.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- key_in  input  4  raw request lines, asynchronous to clk, may bounce
- clr  input  4  per-channel pending clear mask, sampled on clk
- key_lvl  output  4  debounced level per channel (registered)
- key_rise  output  4  one-cycle pulse per channel on debounced 0->1 (registered)
- pend  output  4  sticky pending requests; feeds encoder request input
- pend_any  output  1  OR of pend; feeds encoder enable (registered, equals |pend every cycle)

Behaviour:
- Reset is asynchronous, active-high. While rst=1, these are all 0: key_lvl, key_rise, pend, pend_any, all counters and all synchronizer flops. The first update after release is on the next rising edge of clk with rst=0.
- Sample s[i]: key_in[i] taken directly at the edge (no macro), or the output of the synchronizer (macro on, see Optional Feature).
- Per-channel debounce, evaluated each edge:
  - s[i]==key_lvl[i]: cnt[i] <= 0.
  - s[i]!=key_lvl[i] and cnt[i]<DB_CYCLES-1: cnt[i] <= cnt[i]+1.
  - s[i]!=key_lvl[i] and cnt[i]==DB_CYCLES-1: key_lvl[i] <= s[i], cnt[i] <= 0.
- Result: key_lvl[i] flips on the DB_CYCLES-th consecutive edge that samples the new value. Any edge that samples the old value restarts the count from 0.
- Edge detect: key_rise[i] <= 1 on the same edge key_lvl[i] goes 0->1, else 0. The pulse is exactly one cycle wide. No pulse on 1->0.
- Pending, per channel, each edge:
  - key_rise-qualifying event (the level flip itself, same edge): pend[i] <= 1.
  - else if clr[i]: pend[i] <= 0.
  - else: hold.
  - Set wins over a simultaneous clear.
- pend_any is the registered OR of the next-state pend. It matches |pend in every cycle, with no extra lag.
- Channels are fully independent; multiple channels may set or clear on the same edge.
- Releasing a key does not clear pend; only clr does. clr on a channel with pend=0 has no effect.
- Reset asserted mid-count or mid-pulse: everything returns to 0 immediately. A key held through reset release is re-debounced from cnt=0 and produces a fresh key_rise.
- No combinational path from any input to any output.

Optional Feature:
- Macro: KEY_REQ_SYNC2_EN
- Defined: each key_in bit passes through a 2-flop synchronizer (reset to 0) before debounce. Every debounce latency grows by exactly 2 clk cycles.
- Undefined: key_in is sampled directly by the debounce logic. The integrator must guarantee key_in is already synchronous to clk.
- Port list and all other behaviour are identical in both builds.

Test Plan:
- Reset: assert rst mid-operation with key_in=4'b1111 and pend=4'b0101 -> all outputs 0 immediately (asynchronous). After release, with DB_CYCLES=4 and no macro, key_lvl=4'b1111 and key_rise=4'b1111 for one cycle at the 4th edge, then pend=4'b1111 and pend_any=1.
- Clean press: key_in[2] 0->1 held stable, DB_CYCLES=4 -> key_lvl[2] and key_rise[2] rise on the 4th edge; key_rise[2]=0 on the 5th edge; pend=4'b0100 and pend_any=1 from the 4th edge. With KEY_REQ_SYNC2_EN defined, the same event lands on the 6th edge.
- Bounce reject: key_in[1] pattern 1,1,1,0,1,1,1,1 (one value per edge) -> no flip through edge 3; counter restarts at edge 4; key_lvl[1]=1 at edge 8; exactly one key_rise[1] pulse.
- Clear vs set collision: pend[0]=1, clr=4'b0001 on the same edge key_lvl[3] rises and key_lvl[0] rises again after a release/press -> pend=4'b1001 (set wins on ch0). A following clr=4'b1001 -> pend=4'b0000, pend_any=0.
- Release without clear: press ch3, then release ch3 stably for 4 edges -> key_lvl[3]=0, no key_rise pulse, pend[3] stays 1 until clr[3]=1.
- Simultaneous multi-key: key_in 4'b0000 -> 4'b1011 stable -> key_rise=4'b1011 for one cycle, pend=4'b1011; the downstream encoder then sees I=4'b1011 with en=1.
